// File: rtl/vga_capture.sv
// vga_capture: receive side of the monochrome VGA loopback.
// Samples hs/vs/pixel on the pixel-clock enable, locks onto the sync timing,
// measures line length and frame height, and packs active-area pixels
// into bytes for a 1-bpp framebuffer write port.
//
// Ports:
//   clock      system clock
//   reset      synchronous, active-high
//   ce         pixel-clock enable; all sampling and counting gated by it
//   hs, vs     active-high sync inputs
//   pixel      video data bit
//   locked     timing locked, capture active
//   h_period   measured ce samples per line
//   v_lines    measured hs periods per frame
//   wr_en      one-clock framebuffer write strobe
//   wr_addr    byte address = row*(H_ACTIVE/8) + col/8
//   wr_data    packed pixels, leftmost pixel in bit 7
//   frame_done one-clock pulse alongside the last byte of a frame
//   sync_err   one-clock pulse when lock is lost
module vga_capture #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned H_START  = 17,
    parameter int unsigned V_START  = 10,
    parameter int unsigned TIMEOUT  = 2047
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    input  logic        hs,
    input  logic        vs,
    input  logic        pixel,
    output logic        locked,
    output logic [11:0] h_period,
    output logic [10:0] v_lines,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        frame_done,
    output logic        sync_err
);
    localparam logic [11:0] H_LO   = 12'(H_START);
    localparam logic [11:0] H_HI   = 12'(H_START + H_ACTIVE);
    localparam logic [10:0] V_LO   = 11'(V_START);
    localparam logic [10:0] V_HI   = 11'(V_START + V_ACTIVE);
    localparam logic [11:0] H_TO   = 12'(TIMEOUT);
    localparam logic [11:0] H_LAST = 12'(H_ACTIVE - 1);
    localparam logic [10:0] V_LAST = 11'(V_ACTIVE - 1);
    localparam logic [15:0] BPL    = 16'(H_ACTIVE / 8);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
    state_t state_q, state_d;

    logic        hs_q, vs_q;
    logic [11:0] hcnt;
    logic [10:0] vcnt;
    logic [7:0]  shreg;
    logic        meas_first;   // no line length recorded yet in this MEASURE stay
    logic        meas_bad;     // a line of unequal length seen this frame

    logic        hs_fall, vs_fall;
    logic [11:0] hcnt_n, line_len, col;
    logic [10:0] vcnt_n, row;
    logic        h_bad, v_bad, timeout, lose_lock, meas_bad_n, active;
    logic [7:0]  pack_n;

    // Counter values of the current sample: the sample showing the hs
    // falling edge is sample 0 of the line.
    always_comb begin
        hs_fall  = ce && hs_q && !hs;
        vs_fall  = ce && vs_q && !vs;
        line_len = hcnt + 12'd1;
        if (hs_fall)
            hcnt_n = '0;
        else if (hcnt == '1)
            hcnt_n = hcnt;
        else
            hcnt_n = hcnt + 12'd1;
        if (vs_fall)
            vcnt_n = '0;
        else if (hs_fall && vcnt != '1)
            vcnt_n = vcnt + 11'd1;
        else
            vcnt_n = vcnt;
        h_bad      = hs_fall && (line_len != h_period);
        v_bad      = vs_fall && (vcnt != v_lines);
        timeout    = ce && (hcnt_n >= H_TO);
        meas_bad_n = meas_bad || (h_bad && !meas_first);
        col        = hcnt_n - H_LO;
        row        = vcnt_n - V_LO;
        active     = ce && (hcnt_n >= H_LO) && (hcnt_n < H_HI)
                        && (vcnt_n >= V_LO) && (vcnt_n < V_HI);
        // First pixel of a byte starts from a clean byte so stale bits
        // from an aborted byte never leak into a write.
        pack_n = (col[2:0] == 3'd0) ? '0 : shreg;
        pack_n[3'd7 - col[2:0]] = pixel;
    end

    always_comb begin
        state_d   = state_q;
        lose_lock = 1'b0;
        case (state_q)
            SEARCH:  if (vs_fall) state_d = MEASURE;
            MEASURE: begin
                if (timeout)
                    state_d = SEARCH;
                else if (vs_fall && !meas_first && !meas_bad_n)
                    state_d = LOCKED;
            end
            LOCKED: begin
                if (h_bad || v_bad || timeout) begin
                    lose_lock = 1'b1;
                    state_d   = SEARCH;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= SEARCH;
            locked     <= 1'b0;
            h_period   <= '0;
            v_lines    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            hcnt       <= '0;
            vcnt       <= '0;
            shreg      <= '0;
            meas_first <= 1'b1;
            meas_bad   <= 1'b0;
        end else begin
            state_q    <= state_d;
            locked     <= (state_d == LOCKED);
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= lose_lock;
            if (ce) begin
                hs_q <= hs;
                vs_q <= vs;
                hcnt <= hcnt_n;
                vcnt <= vcnt_n;
                if (state_q == MEASURE) begin
                    if (hs_fall) begin
                        h_period   <= line_len;
                        meas_first <= 1'b0;
                    end
                    if (vs_fall) begin
                        v_lines  <= vcnt;
                        meas_bad <= 1'b0;
                    end else begin
                        meas_bad <= meas_bad_n;
                    end
                end else begin
                    meas_first <= 1'b1;
                    meas_bad   <= 1'b0;
                end
                if (state_q == LOCKED && !lose_lock && active) begin
                    shreg <= pack_n;
                    if (col[2:0] == 3'd7) begin
                        wr_en      <= 1'b1;
                        wr_data    <= pack_n;
                        wr_addr    <= 16'(row) * BPL + 16'(col >> 3);
                        frame_done <= (row == V_LAST) && (col == H_LAST);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture using a reduced raster: 40-sample lines with hs high
// on samples 30..33, 10-line frames with vs high on lines 7..8, and a
// 16x4 active area whose pixel x appears on line sample x+1.
module tb_vga_capture;
    localparam int HT  = 40;
    localparam int VT  = 10;
    localparam int HA  = 16;
    localparam int VA  = 4;
    localparam int HST = 7;     // hs falls at sample 34; 34 + 7 = 41 = next line sample 1
    localparam int VST = 1;     // one hs fall (line 9) between vs fall and line 0
    localparam int TO  = 100;
    localparam int FRAME = HT * VT;
    localparam logic [15:0] LAST = 16'd7;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0, hs = 1'b0, vs = 1'b0, pixel = 1'b0;
    logic        locked, wr_en, frame_done, sync_err;
    logic [11:0] h_period;
    logic [10:0] v_lines;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;

    vga_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_START(HST), .V_START(VST), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .ce(ce), .hs(hs), .vs(vs), .pixel(pixel),
        .locked(locked), .h_period(h_period), .v_lines(v_lines),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .sync_err(sync_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int ce_div = 2;
    int smp_cnt = 0;
    int fd_cnt = 0;
    int se_cnt = 0;
    int err_sample = -1;
    logic [23:0] wq[$];
    logic [63:0] cur_img = '0;

    typedef struct {
        string       name;
        logic [63:0] img;   // row 0 in the top 16 bits, leftmost pixel first
        logic [63:0] exp;   // byte at address 0 in the top 8 bits
        int          div;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (wr_en) wq.push_back({wr_addr, wr_data});
        if (frame_done) begin
            fd_cnt++;
            check("fd_align", {wr_en, wr_addr}, {1'b1, LAST});
        end
        if (sync_err) begin
            se_cnt++;
            err_sample = smp_cnt;
        end
    end

    function automatic logic pix_at(input int y, input int x);
        if (y < VA && x >= 1 && x <= HA) return cur_img[63 - (y * HA + x - 1)];
        return 1'b0;
    endfunction

    task automatic send_sample(input logic h, input logic v, input logic p);
        hs = h; vs = v; pixel = p; ce = 1'b1;
        @(posedge clock); #1;
        ce = 1'b0;
        for (int k = 1; k < ce_div; k++) begin
            @(posedge clock); #1;
        end
        smp_cnt++;
    endtask

    // Raster samples with linear index s0 .. s1-1 (s = line*HT + sample).
    task automatic send_span(input int s0, input int s1);
        for (int s = s0; s < s1; s++) begin
            int y, x;
            y = s / HT;
            x = s % HT;
            send_sample(x >= 30 && x <= 33, y >= 7 && y <= 8, pix_at(y, x));
        end
    endtask

    task automatic clear_mon();
        wq.delete();
        fd_cnt = 0;
        se_cnt = 0;
        err_sample = -1;
    endtask

    task automatic check_capture(input string tag, input logic [63:0] expb, input int n, input int fd);
        check({tag, "_nwr"}, wq.size(), n);
        for (int i = 0; i < n && i < wq.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wq[i][23:8], i);
            check($sformatf("%s_data%0d", tag, i), wq[i][7:0], expb[63 - 8 * i -: 8]);
        end
        check({tag, "_fd"}, fd_cnt, fd);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_hper"}, h_period, 0);
        check({tag, "_vlin"}, v_lines, 0);
        check({tag, "_wren"}, wr_en, 0);
        check({tag, "_waddr"}, wr_addr, 0);
        check({tag, "_wdata"}, wr_data, 0);
        check({tag, "_fdone"}, frame_done, 0);
        check({tag, "_serr"}, sync_err, 0);
    endtask

    // Two frames after loss of lock: one measuring frame with no capture,
    // then a captured frame that must match the given image.
    task automatic relock(input string tag);
        clear_mon();
        send_span(0, FRAME);
        check({tag, "_meas"}, wq.size(), 0);
        check({tag, "_lock1"}, locked, 1);
        clear_mon();
        send_span(0, FRAME);
        check_capture({tag, "_cap"}, vecs[0].exp, 8, 1);
    endtask

    initial begin
        int base;
        vecs[0] = '{"checker",   64'hAAAA_5555_AAAA_5555, 64'hAAAA_5555_AAAA_5555, 2};
        vecs[1] = '{"corners",   64'h8001_0000_0000_0000, 64'h8001_0000_0000_0000, 2};
        vecs[2] = '{"glyph_ce4", 64'h7C00_00FF_F00F_1234, 64'h7C00_00FF_F00F_1234, 4};
        vecs[3] = '{"glyph_ce3", 64'h7C00_00FF_F00F_1234, 64'h7C00_00FF_F00F_1234, 3};
        vecs[4] = '{"walk",      64'h0102_0408_1020_4080, 64'h0102_0408_1020_4080, 2};

        repeat (3) @(posedge clock);
        #1;
        check_zero("rst");
        reset = 1'b0;

        // Frame 0: vs fall moves to MEASURE; frame 1: lock at its vs fall.
        clear_mon();
        send_span(0, FRAME);
        check("f0_locked", locked, 0);
        check("f0_nwr", wq.size(), 0);
        clear_mon();
        send_span(0, FRAME);
        check("f1_locked", locked, 1);
        check("f1_hper", h_period, HT);
        check("f1_vlin", v_lines, VT);
        check("f1_nwr", wq.size(), 0);

        foreach (vecs[i]) begin
            cur_img = vecs[i].img;
            ce_div  = vecs[i].div;
            clear_mon();
            send_span(0, FRAME);
            check_capture(vecs[i].name, vecs[i].exp, 8, 1);
            check({vecs[i].name, "_locked"}, locked, 1);
            check({vecs[i].name, "_serr"}, se_cnt, 0);
        end

        // Line 5 stretched to 41 samples: error at line 6's hs fall.
        cur_img = vecs[0].img;
        ce_div = 2;
        clear_mon();
        send_span(0, 6 * HT);
        send_sample(1'b0, 1'b0, 1'b0);
        send_span(6 * HT, FRAME);
        check_capture("stretch", vecs[0].exp, 8, 1);
        check("stretch_serr", se_cnt, 1);
        check("stretch_locked", locked, 0);
        relock("stretch_re");

        // hs held low: lock dropped when hcnt reaches TO (hcnt was 5 at frame end).
        clear_mon();
        base = smp_cnt;
        for (int k = 0; k < 150; k++) send_sample(1'b0, 1'b0, 1'b0);
        check("to_serr", se_cnt, 1);
        check("to_at", err_sample, base + (TO - 6));
        check("to_locked", locked, 0);
        clear_mon();
        send_span(0, FRAME);
        check("to_search", wq.size(), 0);
        relock("to_re");

        // Reset while sample col 5 of row 1 is pending: row 0 bytes survive only.
        clear_mon();
        send_span(0, HT + 6);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check_zero("midrst");
        send_span(HT + 5, FRAME);
        check_capture("midrst_part", vecs[0].exp, 2, 0);
        relock("midrst_re");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
